// File: rtl/bram_arb_pkg.sv
// Shared definitions for the BRAM read arbiter slice.
//   RESP_Q_DEPTH : depth of the tagged response queue (credit limit)
//   clog2()      : constant-friendly ceiling log2
//   resp_entry_t : queue entry {id, data} at the default widths; the top
//                  declares the same layout at its own parameter widths.
package bram_arb_pkg;

  localparam int RESP_Q_DEPTH   = 2;
  localparam int DEF_ID_WIDTH   = 2;
  localparam int DEF_DATA_WIDTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_DATA_WIDTH-1:0] data;
  } resp_entry_t;

endpackage

// File: rtl/bram_rd_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req          : request vector
//   ptr          : highest-priority index (must be < N)
//   grant_onehot : one-hot grant, first set req at or above ptr, wrapping
//   grant_idx    : binary index of the grant
//   any_grant    : at least one request granted
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  int j;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    j            = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any_grant && req[j]) begin
        any_grant       = 1'b1;
        grant_onehot[j] = 1'b1;
        grant_idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bram_rd_arbiter.sv
// Round-robin sharing of a 1-cycle-latency, read-first BRAM read port among
// NUM_REQ requesters, with a tagged 2-entry response queue and a pass-through
// write port.
//   req_valid/req_addr/req_ready : per-requester read requests, one-hot grant
//   resp_valid/resp_id/resp_data/resp_ready : shared tagged response channel
//   wr_en/wr_addr/wr_data        : write stream, forwarded to ram_w*
//   ram_raddr/ram_rdata          : RAM read port (data one cycle after addr)
// Optional: define BRAM_RD_ARB_BYPASS_EN for write-first behaviour when a read
// issues in the same cycle as a write to the same address.
module bram_rd_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [DATA_WIDTH-1:0]         resp_data,
  input  logic                          resp_ready,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic [ADDR_WIDTH-1:0]         ram_raddr,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  output logic                          ram_wr_en,
  output logic [ADDR_WIDTH-1:0]         ram_waddr,
  output logic [DATA_WIDTH-1:0]         ram_wdata
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
  } q_entry_t;

  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [NUM_REQ-1:0]    arb_req;
  logic                  issue;
  logic                  issue_ok;
  logic [2:0]            occ;
  logic                  infl_vld_q;
  logic [ID_WIDTH-1:0]   infl_id_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [1:0]            count_q, count_d;
  logic                  head_q, tail_q;
  logic                  push, pop;
  q_entry_t              push_entry;
  q_entry_t              q_mem [RESP_Q_DEPTH];

  assign ram_wr_en = wr_en;
  assign ram_waddr = wr_addr;
  assign ram_wdata = wr_data;

  assign resp_valid = (count_q != 2'd0);
  assign pop        = resp_valid & resp_ready;
  assign push       = infl_vld_q;

  // A slot freed by this cycle's pop is reusable by this cycle's issue, which
  // is what sustains one response per cycle with a 2-deep queue.
  assign occ      = {1'b0, count_q} - {2'b0, pop} + {2'b0, infl_vld_q};
  assign issue_ok = (occ < 3'd2);
  // rst_n gate keeps req_ready low while reset is asserted.
  assign arb_req  = req_valid & {NUM_REQ{issue_ok & rst_n}};

  rr_arbiter #(.N(NUM_REQ), .IW(ID_WIDTH)) u_arb (
    .req          (arb_req),
    .ptr          (rr_ptr_q),
    .grant_onehot (req_ready),
    .grant_idx    (gnt_idx),
    .any_grant    (issue)
  );

  // Address holds its last granted value on idle cycles.
  assign ram_raddr = issue ? req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH] : raddr_q;
  assign rr_ptr_d  = (gnt_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      infl_vld_q <= 1'b0;
      infl_id_q  <= '0;
      raddr_q    <= '0;
    end else begin
      infl_vld_q <= issue;
      if (issue) begin
        rr_ptr_q  <= rr_ptr_d;
        infl_id_q <= gnt_idx;
        raddr_q   <= ram_raddr;
      end
    end
  end

`ifdef BRAM_RD_ARB_BYPASS_EN
  logic                  byp_hit_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q <= issue & wr_en & (wr_addr == ram_raddr);
      if (issue & wr_en & (wr_addr == ram_raddr)) byp_data_q <= wr_data;
    end
  end

  assign push_entry = '{id: infl_id_q, data: byp_hit_q ? byp_data_q : ram_rdata};
`else
  assign push_entry = '{id: infl_id_q, data: ram_rdata};
`endif

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) tail_q <= ~tail_q;
      if (pop)  head_q <= ~head_q;
    end
  end

  // Storage needs no reset: count_q alone decides validity.
  always_ff @(posedge clk) begin
    if (push) q_mem[tail_q] <= push_entry;
  end

  assign resp_id   = resp_valid ? q_mem[head_q].id   : '0;
  assign resp_data = resp_valid ? q_mem[head_q].data : '0;

endmodule

// File: tb/tb_bram_rd_arbiter.sv
module tb_bram_rd_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [7:0]  resp_data;
  logic        resp_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  ram_raddr;
  logic [7:0]  ram_rdata;
  logic        ram_wr_en;
  logic [3:0]  ram_waddr;
  logic [7:0]  ram_wdata;

  bram_rd_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(4), .DATA_WIDTH(8), .ID_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_wr_en(ram_wr_en), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous RAM behind the arbiter
  logic [7:0] mem [16];
  always @(posedge clk) begin
    ram_rdata <= mem[ram_raddr];
    if (ram_wr_en) mem[ram_waddr] <= ram_wdata;
  end

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic [3:0] rv;
    logic       rr;
    logic [3:0] exp_gnt;
    logic       exp_rv;
    logic [1:0] exp_id;
    logic [7:0] exp_data;
  } vec_t;

  int         checks;
  int         fails;
  logic [7:0] ref_mem [16];
  exp_t       sb [$];
  int         m_out;
  int         m_infl;
  int         m_ptr;
  int         hs;
  vec_t       tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_out  = 0;
    m_infl = 0;
    m_ptr  = 0;
  endtask

  // Reference model of credit, round-robin grant, ordering and data.
  task automatic monitor();
    int         qc;
    logic       pop;
    logic       ok;
    logic [3:0] eg;
    int         g;
    logic [3:0] a;
    exp_t       e;
    qc = m_out - m_infl;
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, qc > 0});
    pop = resp_valid & resp_ready;
    ok  = (m_out - int'(pop)) < 2;
    eg  = '0;
    g   = -1;
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (g < 0 && req_valid[j]) begin
          g     = j;
          eg[j] = 1'b1;
        end
      end
    end
    chk("grant", {28'd0, req_ready}, {28'd0, eg});
    if (pop) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL resp_extra: got id %0h data %0h expected no response", resp_id, resp_data);
      end else begin
        chk("resp_id", {30'd0, resp_id}, {30'd0, sb[0].id});
        chk("resp_data", {24'd0, resp_data}, {24'd0, sb[0].data});
        void'(sb.pop_front());
        m_out--;
      end
    end
    if (g >= 0) begin
      a      = req_addr[g*4 +: 4];
      e.id   = g[1:0];
      e.data = ref_mem[a];
`ifdef BRAM_RD_ARB_BYPASS_EN
      if (wr_en && wr_addr == a) e.data = wr_data;
`endif
      sb.push_back(e);
      m_out++;
      hs++;
      m_ptr  = (g + 1) % 4;
      m_infl = 1;
    end else begin
      m_infl = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    if (wr_en) ref_mem[wr_addr] = wr_data;
    #1;
  endtask

  initial begin
    checks = 0; fails = 0; hs = 0;
    model_clear();
    rst_n = 1'b0; req_valid = 4'b1111; req_addr = '0; resp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // reset state
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_id", {30'd0, resp_id}, 32'd0);
    chk("rst_resp_data", {24'd0, resp_data}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    adv(); adv();
    rst_n = 1'b1; req_valid = '0;

    // fill memory: mem[i] = 8'h10 + i
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = i[3:0]; wr_data = 8'h10 + i[7:0];
      tick(); adv();
    end
    wr_en = 1'b0;

    // round-robin, 1/cycle, 2-cycle latency
    tbl[0] = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00};
    tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 8'h00};
    tbl[2] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 8'h10};
    tbl[3] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 8'h11};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 8'h12};
    tbl[5] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3, 8'h13};
    tbl[6] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h10};
    tbl[7] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 8'h11};
    tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    req_addr = {4'd3, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].rv; resp_ready = tbl[i].rr;
      tick();
      chk("rr_grant", {28'd0, req_ready}, {28'd0, tbl[i].exp_gnt});
      chk("rr_resp_valid", {31'd0, resp_valid}, {31'd0, tbl[i].exp_rv});
      if (tbl[i].exp_rv) begin
        chk("rr_resp_id", {30'd0, resp_id}, {30'd0, tbl[i].exp_id});
        chk("rr_resp_data", {24'd0, resp_data}, {24'd0, tbl[i].exp_data});
      end
      adv();
    end

    // backpressure: exactly two issues with no consumer
    hs = 0; req_valid = 4'b0100; resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); adv();
    end
    chk("bp_handshakes", hs, 32'd2);
    tick();
    chk("bp_stalled", {28'd0, req_ready}, 32'd0);
    adv();
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_resume_grant", {28'd0, req_ready}, 32'b0100);
      chk("bp_resume_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_resume_data", {24'd0, resp_data}, 32'h12);
      adv();
    end
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin tick(); adv(); end
    chk("bp_drained", sb.size(), 32'd0);

    // single requester with gaps; pointer wraps 3 -> 0
    req_valid = 4'b1000; tick(); chk("gap_g1", {28'd0, req_ready}, 32'b1000); adv();
    req_valid = 4'b0000; tick(); chk("gap_g0", {28'd0, req_ready}, 32'b0000); adv();
    req_valid = 4'b1000; tick(); chk("gap_g2", {28'd0, req_ready}, 32'b1000); adv();
    req_valid = 4'b1111; tick(); chk("gap_wrap", {28'd0, req_ready}, 32'b0001); adv();
    req_valid = 4'b0000;
    for (int i = 0; i < 3; i++) begin tick(); adv(); end

    // same-cycle write/read collision at address 5
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hAA; tick(); adv();
    req_addr = {4'd3, 4'd2, 4'd1, 4'd5};
    req_valid = 4'b0001; wr_data = 8'h55;
    tick(); chk("col_grant", {28'd0, req_ready}, 32'b0001); adv();
    req_valid = '0; wr_en = 1'b0;
    tick(); adv();
    tick();
    chk("col_valid", {31'd0, resp_valid}, 32'd1);
`ifdef BRAM_RD_ARB_BYPASS_EN
    chk("col_data", {24'd0, resp_data}, 32'h55);
`else
    chk("col_data", {24'd0, resp_data}, 32'hAA);
`endif
    adv();
    req_valid = 4'b0001; tick(); adv();
    req_valid = '0; tick(); adv();
    tick();
    chk("col_reread", {24'd0, resp_data}, 32'h55);
    adv();

    // reset while a read is in flight and the queue holds an entry
    req_addr = {4'd3, 4'd2, 4'd1, 4'd0};
    resp_ready = 1'b0; req_valid = 4'b1111;
    tick(); adv(); tick(); adv();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    adv(); adv();
    rst_n = 1'b1; req_valid = '0; resp_ready = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("post_rst_ready", {28'd0, req_ready}, 32'd0);
      adv();
    end
    req_valid = 4'b1111;
    tick(); chk("post_rst_first", {28'd0, req_ready}, 32'b0001); adv();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin tick(); adv(); end

    // random soak against the reference model
    for (int i = 0; i < 10000; i++) begin
      req_valid  = 4'($urandom);
      req_addr   = 16'($urandom);
      resp_ready = ($urandom_range(0, 9) < 7);
      wr_en      = 1'($urandom);
      wr_addr    = 4'($urandom);
      wr_data    = 8'($urandom);
      tick(); adv();
    end
    req_valid = '0; wr_en = 1'b0; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); adv(); end
    chk("soak_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
